// File: rtl/axi_write_master.sv
// axi_write_master: accepts a user write request (address + beat count),
// splits it into AXI4 write bursts of up to WBURST_LEN beats, streams user
// data onto W and collects B responses, pulsing wr_done when finished.
// Optional feature macro: AXI_WR_WAIT_BRESP_EN
//   defined   -> each new AW waits for the previous burst's B response.
//   undefined -> bursts are issued back to back; an 8-bit counter tracks
//                outstanding B responses and bready is held high.
module axi_write_master #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 16,
  parameter int DATA_LEVEL = 2,
  parameter int WBURST_LEN = 8,
  parameter int RBURST_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_end,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic                  axi_wlast,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic                  wr_trig,
  input  logic [7:0]            wr_len,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_en,
  output logic                  wr_ready,
  output logic                  wr_done
);

  // Reject out-of-range burst lengths at elaboration; RBURST_LEN is only
  // range-checked because the write path never uses it.
  if ((WBURST_LEN < 1) || (WBURST_LEN > 256) || (RBURST_LEN < 1) || (RBURST_LEN > 256)) begin : g_bad_burst_len
    $error("axi_write_master: burst length parameters must be within 1..256");
  end

  localparam logic [8:0] WB_MAX = 9'(WBURST_LEN);
  localparam logic [7:0] WB_M1  = 8'(WBURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2,
    S_B    = 2'd3
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;      // start address of the current burst
  logic [7:0]            remain_q;    // beats not yet covered by a finished burst
  logic [7:0]            beat_cnt_q;  // beats left in the burst after the current one
  logic                  awvalid_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic                  wvalid_q;
  logic                  wlast_q;
  logic                  bready_q;
  logic                  wr_ready_q;
  logic                  wr_done_q;

  logic [7:0]            beats_s;
  logic [7:0]            remain_d;
  logic [ADDR_WIDTH-1:0] addr_d;

  // AWLEN for the next burst: min(remaining, WBURST_LEN) - 1 (rem is never 0 here).
  function automatic logic [7:0] burst_awlen(input logic [7:0] rem);
    if ({1'b0, rem} > WB_MAX) begin
      return WB_M1;
    end else begin
      return rem - 8'd1;
    end
  endfunction

  // Address and remaining count once the current burst is retired.
  always_comb begin
    beats_s  = awlen_q + 8'd1;
    remain_d = remain_q - beats_s;
    addr_d   = addr_q + (ADDR_WIDTH'(beats_s) * ADDR_WIDTH'(DATA_LEVEL));
  end

`ifndef AXI_WR_WAIT_BRESP_EN
  logic [7:0] outst_q;
  logic [7:0] outst_d;
  logic       burst_end_s;
  logic       b_hs_s;

  // Count bursts whose data is sent but whose B response has not arrived.
  always_comb begin
    burst_end_s = wvalid_q & axi_wready & wlast_q;
    b_hs_s      = axi_bvalid & bready_q;
    outst_d     = outst_q;
    if (burst_end_s && !b_hs_s) begin
      outst_d = outst_q + 8'd1;
    end else if (!burst_end_s && b_hs_s && (outst_q != 8'd0)) begin
      outst_d = outst_q - 8'd1;
    end else begin
      outst_d = outst_q;
    end
  end
`endif

  // Main request FSM with all AXI and user-side outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= 8'd0;
      beat_cnt_q <= 8'd0;
      awvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      awlen_q    <= 8'd0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      bready_q   <= 1'b0;
      wr_ready_q <= 1'b0;
      wr_done_q  <= 1'b0;
`ifndef AXI_WR_WAIT_BRESP_EN
      outst_q    <= 8'd0;
`endif
    end else begin
      wr_done_q <= 1'b0;
`ifndef AXI_WR_WAIT_BRESP_EN
      bready_q  <= 1'b1;
      outst_q   <= outst_d;
`endif
      case (state_q)
        S_IDLE: begin
          if (wr_trig && wr_ready_q) begin
            wr_ready_q <= 1'b0;
            addr_q     <= wr_addr;
            remain_q   <= wr_len;
            if (wr_len == 8'd0) begin
              wr_done_q <= 1'b1;
            end else begin
              awvalid_q <= 1'b1;
              awaddr_q  <= wr_addr;
              awlen_q   <= burst_awlen(wr_len);
              state_q   <= S_AW;
            end
          end else begin
            wr_ready_q <= init_end;
          end
        end
        S_AW: begin
          if (axi_awready) begin
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b1;
            wlast_q    <= (awlen_q == 8'd0);
            beat_cnt_q <= awlen_q;
            state_q    <= S_W;
          end
        end
        S_W: begin
          if (axi_wready) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
`ifdef AXI_WR_WAIT_BRESP_EN
              bready_q <= 1'b1;
              state_q  <= S_B;
`else
              addr_q   <= addr_d;
              remain_q <= remain_d;
              if (remain_d != 8'd0) begin
                awvalid_q <= 1'b1;
                awaddr_q  <= addr_d;
                awlen_q   <= burst_awlen(remain_d);
                state_q   <= S_AW;
              end else begin
                state_q <= S_B;
              end
`endif
            end else begin
              beat_cnt_q <= beat_cnt_q - 8'd1;
              wlast_q    <= (beat_cnt_q == 8'd1);
            end
          end
        end
        S_B: begin
`ifdef AXI_WR_WAIT_BRESP_EN
          if (axi_bvalid) begin
            bready_q <= 1'b0;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            if (remain_d != 8'd0) begin
              awvalid_q <= 1'b1;
              awaddr_q  <= addr_d;
              awlen_q   <= burst_awlen(remain_d);
              state_q   <= S_AW;
            end else begin
              wr_done_q <= 1'b1;
              state_q   <= S_IDLE;
            end
          end
`else
          if (outst_d == 8'd0) begin
            wr_done_q <= 1'b1;
            state_q   <= S_IDLE;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wlast   = wlast_q;
  // Zero-latency data path; forced to 0 while no beat is offered.
  assign axi_wdata   = wvalid_q ? wr_data : '0;
  assign axi_bready  = bready_q;
  assign wr_data_en  = wvalid_q & axi_wready;
  assign wr_ready    = wr_ready_q;
  assign wr_done     = wr_done_q;

endmodule

// File: tb/tb_axi_write_master.sv
// Directed self-checking bench for axi_write_master (default build).
`timescale 1ns/1ps
module tb_axi_write_master;
  localparam int AW = 27;
  localparam int DW = 16;
`ifdef AXI_WR_WAIT_BRESP_EN
  localparam logic BREADY_IDLE = 1'b0;
`else
  localparam logic BREADY_IDLE = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          rst_n, init_end;
  logic          axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast;
  logic          axi_bvalid, axi_bready;
  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic [DW-1:0] axi_wdata;
  logic          wr_trig, wr_data_en, wr_ready, wr_done;
  logic [7:0]    wr_len;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  axi_write_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_LEVEL(2),
                     .WBURST_LEN(8), .RBURST_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .init_end(init_end),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wlast(axi_wlast), .axi_wdata(axi_wdata),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .wr_trig(wr_trig), .wr_len(wr_len), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_data_en(wr_data_en), .wr_ready(wr_ready), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // observation logs
  logic [AW-1:0] aw_addr_log[$];
  logic [7:0]    aw_len_log[$];
  logic [DW-1:0] w_data_log[$];
  logic          w_last_log[$];
  int en_cnt, en_err, aw_unstable, done_cnt, ready_busy_err, awv_cnt, wv_cnt, ready_hi_cnt;
  logic busy, chk_next, ready_after_done, accepted;
  logic aw_stall_prev;
  logic [AW-1:0] prev_awaddr;
  logic [7:0]    prev_awlen;

  // slave responder configuration/state
  int aw_delay = 0;
  bit wready_toggle = 1'b0;
  int pend_b = 0;
  int aw_cnt = 0;

  function automatic logic [AW-1:0] aw_addr_at(int i);
    if (i < aw_addr_log.size()) return aw_addr_log[i];
    else return '1;
  endfunction

  function automatic logic [7:0] aw_len_at(int i);
    if (i < aw_len_log.size()) return aw_len_log[i];
    else return 8'hff;
  endfunction

  task automatic clear_logs();
    aw_addr_log.delete(); aw_len_log.delete(); w_data_log.delete(); w_last_log.delete();
    en_cnt = 0; en_err = 0; aw_unstable = 0; done_cnt = 0; ready_busy_err = 0;
    awv_cnt = 0; wv_cnt = 0; ready_hi_cnt = 0;
    busy = 1'b0; chk_next = 1'b0; ready_after_done = 1'b0; accepted = 1'b0;
    aw_stall_prev = 1'b0;
  endtask

  // One clock: observe at negedge, then update slave/user inputs #1 after posedge.
  task automatic step();
    logic hs_aw, hs_w, hs_b, last_w;
    @(negedge clk);
    hs_aw = axi_awvalid & axi_awready;
    hs_w  = axi_wvalid & axi_wready;
    hs_b  = axi_bvalid & axi_bready;
    last_w = axi_wlast;
    if (axi_awvalid) awv_cnt++;
    if (axi_wvalid) wv_cnt++;
    if (wr_ready) ready_hi_cnt++;
    if (wr_data_en) en_cnt++;
    if (wr_data_en !== hs_w) en_err++;
    if (aw_stall_prev && (!axi_awvalid || axi_awaddr !== prev_awaddr || axi_awlen !== prev_awlen))
      aw_unstable++;
    aw_stall_prev = axi_awvalid & ~axi_awready;
    prev_awaddr = axi_awaddr;
    prev_awlen = axi_awlen;
    if (hs_aw) begin aw_addr_log.push_back(axi_awaddr); aw_len_log.push_back(axi_awlen); end
    if (hs_w) begin w_data_log.push_back(axi_wdata); w_last_log.push_back(axi_wlast); end
    if (busy && wr_ready) ready_busy_err++;
    if (wr_done) begin
      done_cnt++; busy = 1'b0; chk_next = 1'b1;
    end else if (chk_next) begin
      ready_after_done = wr_ready; chk_next = 1'b0;
    end
    if (wr_trig && wr_ready) begin accepted = 1'b1; busy = 1'b1; end
    @(posedge clk); #1;
    if (!rst_n) begin
      pend_b = 0; aw_cnt = 0;
      axi_bvalid = 1'b0; axi_awready = 1'b0; axi_wready = 1'b1;
    end else begin
      if (hs_b) pend_b--;
      if (hs_w && last_w) pend_b++;
      axi_bvalid = (pend_b > 0);
      if (hs_w) wr_data = wr_data + 16'd1;
      if (hs_aw) aw_cnt = 0;
      if (axi_awvalid && !hs_aw) begin
        if (aw_cnt >= aw_delay) axi_awready = 1'b1;
        else begin axi_awready = 1'b0; aw_cnt++; end
      end else begin
        axi_awready = 1'b0;
      end
      axi_wready = wready_toggle ? ~axi_wready : 1'b1;
    end
  endtask

  // Issue one request and wait (bounded) for acceptance and completion.
  task automatic run_request(input logic [AW-1:0] addr, input logic [7:0] len, output bit ok);
    int n;
    clear_logs();
    wr_addr = addr; wr_len = len; wr_trig = 1'b1;
    n = 0;
    while (!accepted && n < 200) begin step(); n++; end
    wr_trig = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 400) begin step(); n++; end
    step(); step();
    ok = accepted && (done_cnt != 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_end = 1'b0; wr_trig = 1'b0; wr_len = 8'd0; wr_addr = '0;
    wr_data = 16'h1234; axi_awready = 1'b0; axi_wready = 1'b1; axi_bvalid = 1'b0;
    #12;
    checks++;
    if ({axi_awvalid, axi_wvalid, axi_wlast, axi_bready, wr_ready, wr_done, wr_data_en} !== 7'd0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000000",
        {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, wr_ready, wr_done, wr_data_en});
    end
    checks++;
    if (axi_awaddr !== 27'd0 || axi_awlen !== 8'd0 || axi_wdata !== 16'd0) begin
      failures++; $display("FAIL reset_data got=%0h/%0h/%0h exp=0/0/0", axi_awaddr, axi_awlen, axi_wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; init_end = 1'b1;
    clear_logs();
    step(); step(); step();
    checks++;
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
    checks++;
    if (axi_bready !== BREADY_IDLE) begin failures++; $display("FAIL reset_bready got=%b exp=%b", axi_bready, BREADY_IDLE); end
  endtask

  task automatic test_basic_split();
    bit ok; int derr, lerr;
    wr_data = 16'd1;
    run_request(27'h0, 8'd16, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_complete got=%b exp=1", ok); end
    checks++;
    if (aw_addr_log.size() != 2 || aw_addr_at(0) !== 27'h0 || aw_addr_at(1) !== 27'h10) begin
      failures++; $display("FAIL basic_awaddr got=n%0d %0h,%0h exp=n2 0,10", aw_addr_log.size(), aw_addr_at(0), aw_addr_at(1));
    end
    checks++;
    if (aw_len_at(0) !== 8'd7 || aw_len_at(1) !== 8'd7) begin
      failures++; $display("FAIL basic_awlen got=%0d,%0d exp=7,7", aw_len_at(0), aw_len_at(1));
    end
    derr = 0; lerr = 0;
    for (int i = 0; i < w_data_log.size(); i++) begin
      if (w_data_log[i] !== 16'(i + 1)) derr++;
      if (w_last_log[i] !== ((i == 7) || (i == 15))) lerr++;
    end
    checks++;
    if (w_data_log.size() != 16 || derr != 0) begin
      failures++; $display("FAIL basic_wdata got=beats%0d errs%0d exp=beats16 errs0", w_data_log.size(), derr);
    end
    checks++; if (lerr != 0) begin failures++; $display("FAIL basic_wlast got=errs%0d exp=0", lerr); end
    checks++; if (en_cnt != 16) begin failures++; $display("FAIL basic_en_cnt got=%0d exp=16", en_cnt); end
    checks++; if (en_err != 0) begin failures++; $display("FAIL basic_en_match got=%0d exp=0", en_err); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    wr_data = 16'd1;
    run_request(27'h20, 8'd16, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_complete got=%b exp=1", ok); end
    checks++;
    if (aw_addr_log.size() != 2 || aw_addr_at(0) !== 27'h20 || aw_addr_at(1) !== 27'h30) begin
      failures++; $display("FAIL b2b_awaddr got=n%0d %0h,%0h exp=n2 20,30", aw_addr_log.size(), aw_addr_at(0), aw_addr_at(1));
    end
    checks++; if (ready_busy_err != 0) begin failures++; $display("FAIL b2b_ready_busy got=%0d exp=0", ready_busy_err); end
    checks++; if (ready_after_done !== 1'b1) begin failures++; $display("FAIL b2b_ready_after got=%b exp=1", ready_after_done); end
    checks++; if (en_cnt != 16) begin failures++; $display("FAIL b2b_en_cnt got=%0d exp=16", en_cnt); end
  endtask

  task automatic test_partial();
    bit ok; int derr, lerr;
    wr_data = 16'd1;
    run_request(27'h100, 8'd10, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL part_complete got=%b exp=1", ok); end
    checks++;
    if (aw_addr_log.size() != 2 || aw_addr_at(0) !== 27'h100 || aw_addr_at(1) !== 27'h110 ||
        aw_len_at(0) !== 8'd7 || aw_len_at(1) !== 8'd1) begin
      failures++; $display("FAIL part_aw got=n%0d %0h/%0d,%0h/%0d exp=n2 100/7,110/1", aw_addr_log.size(),
        aw_addr_at(0), aw_len_at(0), aw_addr_at(1), aw_len_at(1));
    end
    derr = 0; lerr = 0;
    for (int i = 0; i < w_data_log.size(); i++) begin
      if (w_data_log[i] !== 16'(i + 1)) derr++;
      if (w_last_log[i] !== ((i == 7) || (i == 9))) lerr++;
    end
    checks++;
    if (w_data_log.size() != 10 || derr != 0 || lerr != 0) begin
      failures++; $display("FAIL part_beats got=beats%0d derr%0d lerr%0d exp=beats10 0 0", w_data_log.size(), derr, lerr);
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    run_request(27'h80, 8'd0, ok);
    checks++; if (ok !== 1'b1 || done_cnt != 1) begin failures++; $display("FAIL zero_done got=%0d exp=1", done_cnt); end
    checks++;
    if (awv_cnt != 0 || wv_cnt != 0) begin
      failures++; $display("FAIL zero_no_axi got=aw%0d w%0d exp=aw0 w0", awv_cnt, wv_cnt);
    end
    checks++; if (ready_after_done !== 1'b1) begin failures++; $display("FAIL zero_ready_after got=%b exp=1", ready_after_done); end
  endtask

  task automatic test_gating();
    bit ok;
    init_end = 1'b0;
    step(); step();
    clear_logs();
    wr_addr = 27'h200; wr_len = 8'd4; wr_trig = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++; if (ready_hi_cnt != 0) begin failures++; $display("FAIL gate_ready got=%0d exp=0", ready_hi_cnt); end
    checks++;
    if (awv_cnt != 0 || wv_cnt != 0 || accepted) begin
      failures++; $display("FAIL gate_no_axi got=aw%0d w%0d acc%b exp=0 0 0", awv_cnt, wv_cnt, accepted);
    end
    init_end = 1'b1;
    wr_data = 16'd1;
    run_request(27'h200, 8'd4, ok);
    checks++;
    if (ok !== 1'b1 || aw_addr_log.size() != 1 || aw_addr_at(0) !== 27'h200 || aw_len_at(0) !== 8'd3) begin
      failures++; $display("FAIL gate_release got=ok%b n%0d %0h/%0d exp=ok1 n1 200/3", ok, aw_addr_log.size(), aw_addr_at(0), aw_len_at(0));
    end
  endtask

  task automatic test_backpressure();
    bit ok; int derr, lerr;
    aw_delay = 3; wready_toggle = 1'b1;
    wr_data = 16'd1;
    run_request(27'h300, 8'd12, ok);
    aw_delay = 0; wready_toggle = 1'b0;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_complete got=%b exp=1", ok); end
    checks++;
    if (aw_addr_log.size() != 2 || aw_addr_at(0) !== 27'h300 || aw_addr_at(1) !== 27'h310 ||
        aw_len_at(0) !== 8'd7 || aw_len_at(1) !== 8'd3) begin
      failures++; $display("FAIL bp_aw got=n%0d %0h/%0d,%0h/%0d exp=n2 300/7,310/3", aw_addr_log.size(),
        aw_addr_at(0), aw_len_at(0), aw_addr_at(1), aw_len_at(1));
    end
    checks++; if (aw_unstable != 0) begin failures++; $display("FAIL bp_aw_stable got=%0d exp=0", aw_unstable); end
    checks++; if (awv_cnt != 8) begin failures++; $display("FAIL bp_aw_wait got=%0d exp=8", awv_cnt); end
    checks++; if (en_err != 0 || en_cnt != 12) begin failures++; $display("FAIL bp_en got=err%0d cnt%0d exp=err0 cnt12", en_err, en_cnt); end
    derr = 0; lerr = 0;
    for (int i = 0; i < w_data_log.size(); i++) begin
      if (w_data_log[i] !== 16'(i + 1)) derr++;
      if (w_last_log[i] !== ((i == 7) || (i == 11))) lerr++;
    end
    checks++;
    if (w_data_log.size() != 12 || derr != 0 || lerr != 0) begin
      failures++; $display("FAIL bp_wdata got=beats%0d derr%0d lerr%0d exp=beats12 0 0", w_data_log.size(), derr, lerr);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int n, derr;
    wr_data = 16'd1;
    clear_logs();
    wr_addr = 27'h0; wr_len = 8'd8; wr_trig = 1'b1;
    n = 0;
    while (!accepted && n < 50) begin step(); n++; end
    wr_trig = 1'b0;
    n = 0;
    while (w_data_log.size() < 3 && n < 50) begin step(); n++; end
    checks++; if (axi_wvalid !== 1'b1) begin failures++; $display("FAIL mid_in_burst got=%b exp=1", axi_wvalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({axi_awvalid, axi_wvalid, axi_wlast, axi_bready, wr_ready, wr_done, wr_data_en} !== 7'd0 ||
        axi_awaddr !== 27'd0 || axi_awlen !== 8'd0 || axi_wdata !== 16'd0) begin
      failures++; $display("FAIL mid_async_reset got=%b/%0h/%0h/%0h exp=0",
        {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, wr_ready, wr_done, wr_data_en}, axi_awaddr, axi_awlen, axi_wdata);
    end
    step(); step();
    rst_n = 1'b1;
    step(); step();
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL mid_idle_ready got=%b exp=1", wr_ready); end
    wr_data = 16'd1;
    run_request(27'h40, 8'd8, ok);
    derr = 0;
    for (int i = 0; i < w_data_log.size(); i++) if (w_data_log[i] !== 16'(i + 1)) derr++;
    checks++;
    if (ok !== 1'b1 || aw_addr_log.size() != 1 || aw_addr_at(0) !== 27'h40 || aw_len_at(0) !== 8'd7 ||
        w_data_log.size() != 8 || derr != 0 || done_cnt != 1) begin
      failures++; $display("FAIL mid_recover got=ok%b n%0d %0h/%0d beats%0d derr%0d done%0d exp=ok1 n1 40/7 beats8 0 1",
        ok, aw_addr_log.size(), aw_addr_at(0), aw_len_at(0), w_data_log.size(), derr, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_split();
    test_back_to_back();
    test_partial();
    test_zero_len();
    test_gating();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
